// File: rtl/dekatron_pulse_receiver.sv
// Receiver for the dekatron two-phase guide-pulse bus: validates each half-step pair,
// tracks the glowing cathode (one-hot and binary) and flags carry, borrow and protocol errors.
module dekatron_pulse_receiver #(
  parameter int unsigned MIN_PULSE = 2,
  parameter int unsigned MAX_GAP   = 4,
  parameter int unsigned CNT_W     = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       PulseRight_n,
  input  logic       PulseLeft_n,
  input  logic       Set,
  input  logic [9:0] In,
  input  logic       ErrClr,
  output logic [9:0] Out,
  output logic [3:0] Pos,
  output logic       Step,
  output logic       Dir,
  output logic       Carry,
  output logic       Borrow,
  output logic       Error,
  output logic       Busy
);

  localparam logic [CNT_W-1:0] MinCnt = CNT_W'(MIN_PULSE);
  localparam logic [CNT_W-1:0] MaxGap = CNT_W'(MAX_GAP);
  localparam logic [CNT_W-1:0] OneCnt = CNT_W'(1);

  typedef enum logic [2:0] {
    StIdle, StAFwd, StARev, StGapFwd, StGapRev, StBFwd, StBRev, StWait
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             r_q, l_q;
  logic [9:0]       out_q, out_d;
  logic [3:0]       pos_q, pos_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic             error_q, error_d;

  logic             both_low;
  logic [CNT_W-1:0] cnt_sat;
  logic [CNT_W-1:0] gap_inc;
  logic             fsm_err;
  logic             commit_fwd;
  logic             commit_rev;
  logic             in_onehot;
  logic [3:0]       in_idx;

  assign both_low = !r_q && !l_q;
  assign cnt_sat  = (cnt_q >= MinCnt) ? MinCnt : cnt_q + OneCnt;
  assign gap_inc  = cnt_q + OneCnt;

  // Input stage and FSM state register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_q     <= 1'b1;
      l_q     <= 1'b1;
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      r_q     <= PulseRight_n;
      l_q     <= PulseLeft_n;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; the cycle that enters a pulse state already counts as one low cycle
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fsm_err    = 1'b0;
    commit_fwd = 1'b0;
    commit_rev = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (both_low) begin
          fsm_err = 1'b1;
        end else if (!r_q) begin
          state_d = StAFwd;
          cnt_d   = OneCnt;
        end else if (!l_q) begin
          state_d = StARev;
          cnt_d   = OneCnt;
        end
      end
      StAFwd: begin
        if (both_low) begin
          fsm_err = 1'b1;
        end else if (!r_q) begin
          cnt_d = cnt_sat;
        end else if (cnt_q < MinCnt) begin
          fsm_err = 1'b1;
        end else if (!l_q) begin
          // zero-length gap: second phase already started
          state_d = StBFwd;
          cnt_d   = OneCnt;
        end else begin
          state_d = StGapFwd;
          cnt_d   = OneCnt;
        end
      end
      StARev: begin
        if (both_low) begin
          fsm_err = 1'b1;
        end else if (!l_q) begin
          cnt_d = cnt_sat;
        end else if (cnt_q < MinCnt) begin
          fsm_err = 1'b1;
        end else if (!r_q) begin
          state_d = StBRev;
          cnt_d   = OneCnt;
        end else begin
          state_d = StGapRev;
          cnt_d   = OneCnt;
        end
      end
      StGapFwd: begin
        if (both_low || !r_q) begin
          fsm_err = 1'b1;
        end else if (!l_q) begin
          state_d = StBFwd;
          cnt_d   = OneCnt;
        end else begin
          cnt_d = gap_inc;
          if (gap_inc > MaxGap) fsm_err = 1'b1;
        end
      end
      StGapRev: begin
        if (both_low || !l_q) begin
          fsm_err = 1'b1;
        end else if (!r_q) begin
          state_d = StBRev;
          cnt_d   = OneCnt;
        end else begin
          cnt_d = gap_inc;
          if (gap_inc > MaxGap) fsm_err = 1'b1;
        end
      end
      StBFwd: begin
        if (both_low) begin
          fsm_err = 1'b1;
        end else if (!l_q) begin
          cnt_d = cnt_sat;
        end else if (cnt_q < MinCnt) begin
          fsm_err = 1'b1;
        end else begin
          commit_fwd = 1'b1;
          state_d    = StIdle;
          cnt_d      = '0;
        end
      end
      StBRev: begin
        if (both_low) begin
          fsm_err = 1'b1;
        end else if (!r_q) begin
          cnt_d = cnt_sat;
        end else if (cnt_q < MinCnt) begin
          fsm_err = 1'b1;
        end else begin
          commit_rev = 1'b1;
          state_d    = StIdle;
          cnt_d      = '0;
        end
      end
      StWait: begin
        if (r_q && l_q) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StWait;
        cnt_d   = '0;
      end
    endcase

    if (fsm_err) begin
      state_d = StWait;
      cnt_d   = '0;
    end

    // Set discards any partial step and resynchronises on the next all-high idle
    if (Set) begin
      state_d    = StWait;
      cnt_d      = '0;
      fsm_err    = 1'b0;
      commit_fwd = 1'b0;
      commit_rev = 1'b0;
    end
  end

  assign in_onehot = (In != '0) && ((In & (In - 10'd1)) == '0);

  always_comb begin
    in_idx = '0;
    for (int i = 0; i < 10; i++) begin
      if (In[i]) in_idx = 4'(i);
    end
  end

  // Position and strobe next-state
  always_comb begin
    out_d    = out_q;
    pos_d    = pos_q;
    step_d   = 1'b0;
    dir_d    = dir_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    error_d  = ErrClr ? 1'b0 : error_q;
    if (Set) begin
      if (in_onehot) begin
        out_d = In;
        pos_d = in_idx;
      end else begin
        out_d   = 10'b0000000001;
        pos_d   = '0;
        error_d = 1'b1;
      end
    end else if (fsm_err) begin
      error_d = 1'b1;
    end else if (commit_fwd) begin
      out_d   = {out_q[8:0], out_q[9]};
      pos_d   = (pos_q == 4'd9) ? 4'd0 : pos_q + 4'd1;
      step_d  = 1'b1;
      dir_d   = 1'b0;
      carry_d = (pos_q == 4'd9);
    end else if (commit_rev) begin
      out_d    = {out_q[0], out_q[9:1]};
      pos_d    = (pos_q == 4'd0) ? 4'd9 : pos_q - 4'd1;
      step_d   = 1'b1;
      dir_d    = 1'b1;
      borrow_d = (pos_q == 4'd0);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      out_q    <= 10'b0000000001;
      pos_q    <= '0;
      step_q   <= 1'b0;
      dir_q    <= 1'b0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      out_q    <= out_d;
      pos_q    <= pos_d;
      step_q   <= step_d;
      dir_q    <= dir_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      error_q  <= error_d;
    end
  end

  assign Out    = out_q;
  assign Pos    = pos_q;
  assign Step   = step_q;
  assign Dir    = dir_q;
  assign Carry  = carry_q;
  assign Borrow = borrow_q;
  assign Error  = error_q;
  assign Busy   = (state_q != StIdle);

endmodule
